// File: rtl/data_memory_stage.sv
// MEM-stage data memory: little-endian word array with byte/halfword/word loads and stores,
// combinational load path, alignment fault detection and a sticky first-fault register.
module data_memory_stage #(
    parameter int ADDR_BITS = 8,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address_in,
    input  logic [31:0] write_data_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  mem_size_in,
    input  logic        mem_unsigned_in,
    input  logic        fault_clear_in,
    output logic [31:0] read_data_out,
    output logic [31:0] address_out,
    output logic        misaligned_out,
    output logic        fault_sticky_out,
    output logic [31:0] fault_addr_out,
    output logic [15:0] store_count_out
);

    localparam int DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    logic [31:0]          mem [DEPTH];
    logic [ADDR_BITS-1:0] word_idx;
    logic [1:0]           lane;
    logic                 size_fault;
    logic                 store_commit;
    logic [31:0]          rd_word;
    logic [7:0]           sel_byte;
    logic [15:0]          sel_half;
    logic [3:0]           byte_en;
    logic [31:0]          wr_lanes;

    assign word_idx    = address_in[ADDR_BITS+1:2];
    assign lane        = address_in[1:0];
    assign address_out = address_in;

    always_comb begin
        size_fault = 1'b0;
        case (mem_size_in)
            SIZE_BYTE: size_fault = 1'b0;
            SIZE_HALF: size_fault = lane[0];
            SIZE_WORD: size_fault = (lane != 2'b00);
            default:   size_fault = 1'b1;
        endcase
    end

    assign misaligned_out = (mem_read_in | mem_write_in) & size_fault;
    assign store_commit   = mem_write_in & ~size_fault;

    // Array read is asynchronous so a same-cycle store is only visible after the edge.
    assign rd_word  = mem[word_idx];
    assign sel_byte = rd_word[{lane, 3'b000} +: 8];
    assign sel_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        read_data_out = '0;
        if (mem_read_in && !size_fault) begin
            case (mem_size_in)
                SIZE_BYTE: read_data_out = mem_unsigned_in ? {24'b0, sel_byte}
                                                           : {{24{sel_byte[7]}}, sel_byte};
                SIZE_HALF: read_data_out = mem_unsigned_in ? {16'b0, sel_half}
                                                           : {{16{sel_half[15]}}, sel_half};
                default:   read_data_out = rd_word;
            endcase
        end
    end

    // Store data is replicated across lanes; the enable mask picks which lanes land.
    always_comb begin
        byte_en  = 4'b0000;
        wr_lanes = write_data_in;
        case (mem_size_in)
            SIZE_BYTE: begin
                byte_en  = 4'b0001 << lane;
                wr_lanes = {4{write_data_in[7:0]}};
            end
            SIZE_HALF: begin
                byte_en  = lane[1] ? 4'b1100 : 4'b0011;
                wr_lanes = {2{write_data_in[15:0]}};
            end
            SIZE_WORD: byte_en = 4'b1111;
            default:   byte_en = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if (INIT_ZERO) begin
                for (int i = 0; i < DEPTH; i++) begin
                    mem[i] <= '0;
                end
            end
        end else if (store_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_lanes[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            store_count_out <= '0;
        end else if (store_commit) begin
            store_count_out <= store_count_out + 16'd1;
        end
    end

    // Clear beats a coincident fault; only the first fault after a clear is recorded.
    always_ff @(posedge clk) begin
        if (rst || fault_clear_in) begin
            fault_sticky_out <= 1'b0;
            fault_addr_out   <= '0;
        end else if (misaligned_out && !fault_sticky_out) begin
            fault_sticky_out <= 1'b1;
            fault_addr_out   <= address_in;
        end
    end

endmodule

// File: tb/tb_data_memory_stage.sv
// Scoreboard bench for data_memory_stage: stimulus pushes expectations from a byte-level
// reference model, and a negedge monitor pops and compares them against the DUT outputs.
module tb_data_memory_stage;

    localparam int AB        = 8;
    localparam int MEM_BYTES = 4 << AB;

    localparam int SIG_RD    = 0;
    localparam int SIG_MIS   = 1;
    localparam int SIG_AOUT  = 2;
    localparam int SIG_STICK = 3;
    localparam int SIG_FADDR = 4;
    localparam int SIG_CNT   = 5;

    typedef struct {
        int          cyc;
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] address_in = '0;
    logic [31:0] write_data_in = '0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic [1:0]  mem_size_in = 2'b10;
    logic        mem_unsigned_in = 1'b0;
    logic        fault_clear_in = 1'b0;
    logic [31:0] read_data_out;
    logic [31:0] address_out;
    logic        misaligned_out;
    logic        fault_sticky_out;
    logic [31:0] fault_addr_out;
    logic [15:0] store_count_out;

    data_memory_stage #(.ADDR_BITS(AB), .INIT_ZERO(1'b1)) dut (
        .clk              (clk),
        .rst              (rst),
        .address_in       (address_in),
        .write_data_in    (write_data_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .mem_size_in      (mem_size_in),
        .mem_unsigned_in  (mem_unsigned_in),
        .fault_clear_in   (fault_clear_in),
        .read_data_out    (read_data_out),
        .address_out      (address_out),
        .misaligned_out   (misaligned_out),
        .fault_sticky_out (fault_sticky_out),
        .fault_addr_out   (fault_addr_out),
        .store_count_out  (store_count_out)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   last_cyc = 0;
    int   checks = 0;
    int   errors = 0;
    bit   chk_en = 1'b1;
    exp_t sb[$];

    // Reference model state: a flat byte array plus the architectural registers.
    logic [7:0]  mbytes [MEM_BYTES];
    bit          m_sticky = 1'b0;
    logic [31:0] m_faddr = '0;
    int          m_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    function automatic bit model_fault(input bit rd, input bit wr, input logic [1:0] sz,
                                       input logic [31:0] a);
        int n;
        if (!(rd || wr)) return 1'b0;
        if (sz == 2'd3) return 1'b1;
        n = nbytes(sz);
        return (int'(a % 4) % n) != 0;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input bit uns,
                                               input logic [31:0] a);
        int     ba = int'(a % MEM_BYTES);
        int     n = nbytes(sz);
        longint v = 0;
        for (int k = 0; k < n; k++) v = v + (longint'(mbytes[ba + k]) << (8 * k));
        if (n < 4 && !uns && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
        return v[31:0];
    endfunction

    task automatic model_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
        int ba = int'(a % MEM_BYTES);
        for (int k = 0; k < nbytes(sz); k++) mbytes[ba + k] = 8'((d >> (8 * k)) & 32'hFF);
    endtask

    task automatic pushExpect(input int c, input int sig, input logic [31:0] val, input string name);
        exp_t e;
        e.cyc = c; e.sig = sig; e.val = val; e.name = name;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input bit rd, input bit wr, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] wd,
                                 input bit clr, input bit rs);
        bit          f;
        logic [31:0] exp_rd;
        @(posedge clk);
        #1;
        mem_read_in = rd; mem_write_in = wr; mem_size_in = sz; mem_unsigned_in = uns;
        address_in = a; write_data_in = wd; fault_clear_in = clr; rst = rs;
        last_cyc = cyc;
        f = model_fault(rd, wr, sz, a);
        exp_rd = (rd && !f) ? model_load(sz, uns, a) : 32'h0;
        if (chk_en) begin
            pushExpect(last_cyc, SIG_RD, exp_rd, "read_data");
            pushExpect(last_cyc, SIG_MIS, {31'b0, f}, "misaligned");
            pushExpect(last_cyc, SIG_AOUT, a, "address_out");
        end
        if (rs) begin
            for (int i = 0; i < MEM_BYTES; i++) mbytes[i] = 8'h00;
            m_sticky = 1'b0; m_faddr = '0; m_count = 0;
        end else begin
            if (wr && !f) begin
                model_store(sz, a, wd);
                m_count = (m_count + 1) % 65536;
            end
            if (clr) begin
                m_sticky = 1'b0; m_faddr = '0;
            end else if (f && !m_sticky) begin
                m_sticky = 1'b1; m_faddr = a;
            end
        end
        if (chk_en) begin
            pushExpect(last_cyc + 1, SIG_STICK, {31'b0, m_sticky}, "fault_sticky");
            pushExpect(last_cyc + 1, SIG_FADDR, m_faddr, "fault_addr");
            pushExpect(last_cyc + 1, SIG_CNT, 32'(m_count), "store_count");
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] sampleSig(input int sig);
        case (sig)
            SIG_RD:    return read_data_out;
            SIG_MIS:   return {31'b0, misaligned_out};
            SIG_AOUT:  return address_out;
            SIG_STICK: return {31'b0, fault_sticky_out};
            SIG_FADDR: return fault_addr_out;
            default:   return {16'b0, store_count_out};
        endcase
    endfunction

    // Monitor: every negedge, retire the expectations that belong to this cycle.
    int mi;
    always @(negedge clk) begin
        mi = 0;
        while (mi < sb.size()) begin
            if (sb[mi].cyc == cyc) begin
                checkOutput(sb[mi].name, sampleSig(sb[mi].sig), sb[mi].val);
                sb.delete(mi);
            end else if (sb[mi].cyc < cyc) begin
                checks++;
                errors++;
                $display("[TB] FAIL %s: expectation for cycle %0d never sampled", sb[mi].name, sb[mi].cyc);
                sb.delete(mi);
            end else begin
                mi++;
            end
        end
    end

    task automatic sw(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, a, d, 1'b0, 1'b0);
    endtask

    task automatic ld(input logic [1:0] sz, input bit uns, input logic [31:0] a);
        applyStimulus(1'b1, 1'b0, sz, uns, a, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic idle(input bit clr);
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, clr, 1'b0);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        pushExpect(last_cyc + 1, SIG_CNT, 32'h0, "reset_count");
        pushExpect(last_cyc + 1, SIG_STICK, 32'h0, "reset_sticky");

        sw(32'h10, 32'h8899AABB);
        ld(2'd2, 1'b0, 32'h10);
        pushExpect(last_cyc, SIG_RD, 32'h8899AABB, "lw_0x10");
        pushExpect(last_cyc, SIG_CNT, 32'h1, "count_after_sw");
        ld(2'd0, 1'b0, 32'h10); pushExpect(last_cyc, SIG_RD, 32'hFFFFFFBB, "lb_0x10");
        ld(2'd0, 1'b1, 32'h13); pushExpect(last_cyc, SIG_RD, 32'h00000088, "lbu_0x13");
        ld(2'd1, 1'b0, 32'h12); pushExpect(last_cyc, SIG_RD, 32'hFFFF8899, "lh_0x12");
        ld(2'd1, 1'b1, 32'h10); pushExpect(last_cyc, SIG_RD, 32'h0000AABB, "lhu_0x10");

        applyStimulus(1'b0, 1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055, 1'b0, 1'b0);
        ld(2'd2, 1'b0, 32'h10); pushExpect(last_cyc, SIG_RD, 32'h889955BB, "lw_after_sb");
        applyStimulus(1'b0, 1'b1, 2'd1, 1'b0, 32'h12, 32'h00001234, 1'b0, 1'b0);
        ld(2'd2, 1'b0, 32'h10); pushExpect(last_cyc, SIG_RD, 32'h123455BB, "lw_after_sh");

        sw(32'h22, 32'h11111111);
        pushExpect(last_cyc, SIG_MIS, 32'h1, "sw_0x22_misaligned");
        pushExpect(last_cyc + 1, SIG_STICK, 32'h1, "sticky_set");
        pushExpect(last_cyc + 1, SIG_FADDR, 32'h22, "fault_addr_0x22");
        pushExpect(last_cyc + 1, SIG_CNT, 32'h3, "count_no_fault_store");
        ld(2'd2, 1'b0, 32'h20); pushExpect(last_cyc, SIG_RD, 32'h0, "word8_unchanged");
        ld(2'd1, 1'b0, 32'h31);
        pushExpect(last_cyc, SIG_RD, 32'h0, "faulting_load_zero");
        pushExpect(last_cyc + 1, SIG_FADDR, 32'h22, "fault_addr_kept");
        idle(1'b1);
        pushExpect(last_cyc + 1, SIG_STICK, 32'h0, "clear_sticky");
        pushExpect(last_cyc + 1, SIG_FADDR, 32'h0, "clear_addr");

        sw(32'h400, 32'hDEADBEEF);
        ld(2'd2, 1'b0, 32'h000); pushExpect(last_cyc, SIG_RD, 32'hDEADBEEF, "alias_0x400");

        ld(2'd2, 1'b0, 32'h41);
        applyStimulus(1'b0, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D, 1'b0, 1'b1);
        pushExpect(last_cyc, SIG_STICK, 32'h1, "sticky_before_reset");
        pushExpect(last_cyc + 1, SIG_STICK, 32'h0, "reset_clears_sticky");
        pushExpect(last_cyc + 1, SIG_CNT, 32'h0, "reset_clears_count");
        ld(2'd2, 1'b0, 32'h40); pushExpect(last_cyc, SIG_RD, 32'h0, "reset_discards_store");

        sw(32'h44, 32'hA5A50001);
        applyStimulus(1'b1, 1'b1, 2'd2, 1'b0, 32'h44, 32'h0BADF00D, 1'b0, 1'b0);
        pushExpect(last_cyc, SIG_RD, 32'hA5A50001, "rw_same_cycle_old");
        ld(2'd2, 1'b0, 32'h44); pushExpect(last_cyc, SIG_RD, 32'h0BADF00D, "rw_next_cycle_new");

        applyStimulus(1'b1, 1'b0, 2'd1, 1'b0, 32'h51, 32'h0, 1'b1, 1'b0);
        pushExpect(last_cyc + 1, SIG_STICK, 32'h0, "clear_beats_fault");

        // Random traffic; rare clears and resets exercise priority against live state.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          $urandom(), $urandom(),
                          $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
        end

        applyStimulus(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        chk_en = 1'b0;
        for (int i = 0; i < 65535; i++) sw({$urandom_range(0, 255), 2'b00}, $urandom());
        chk_en = 1'b1;
        idle(1'b0); pushExpect(last_cyc, SIG_CNT, 32'hFFFF, "count_ffff");
        sw(32'h8, 32'h1);
        idle(1'b0); pushExpect(last_cyc, SIG_CNT, 32'h0, "count_wrap");
        idle(1'b0);

        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("[TB] FAIL drain: %0d expectations left unchecked", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/data_memory_stage.md
Name: data_memory_stage

Overview:
- MEM-stage data memory of the five-stage MIPS pipeline. It sits between the EX/MEM register and the MEM/WB register.
- Performs word, halfword and byte loads and stores on a word-organised little-endian array. Loads are sign- or zero-extended.
- Presents load data combinationally, so the MEM/WB register captures it on the next clk edge.
- Detects misaligned or reserved-size accesses, suppresses the faulting store, and records the first fault in a sticky register for the exception logic.

Parameters:
- ADDR_BITS, 8, word-index width; the array holds 2^ADDR_BITS 32-bit words (1 KiB at default).
- INIT_ZERO, 1, when 1 a reset clears every memory word to 0; when 0 reset leaves the array contents untouched.

Ports:
- clk  input  1  pipeline clock; all state updates on its rising edge.
- rst  input  1  synchronous active-high reset.
- address_in  input  32  byte address (ALU result from EX/MEM).
- write_data_in  input  32  store data (rt value); sub-word stores use the low bits.
- mem_read_in  input  1  load enable.
- mem_write_in  input  1  store enable.
- mem_size_in  input  2  access size: 00 byte, 01 halfword, 10 word, 11 reserved.
- mem_unsigned_in  input  1  1 = zero-extend loads (lbu/lhu); 0 = sign-extend.
- fault_clear_in  input  1  clears the sticky fault state.
- read_data_out  output  32  extended load data; combinational.
- address_out  output  32  address_in passed through combinationally, for MEM/WB address_in.
- misaligned_out  output  1  combinational fault indication for the current access.
- fault_sticky_out  output  1  registered; set on the first fault.
- fault_addr_out  output  32  registered; address of the first fault.
- store_count_out  output  16  registered count of committed stores.

Behaviour:
- Word index: address_in[ADDR_BITS+1:2]. Upper address bits are ignored, so addresses alias modulo the array size.
- Byte lane: address_in[1:0]. Lane 0 = bits 7:0 (little-endian).
- Fault condition (misaligned_out = 1) requires (mem_read_in or mem_write_in) and any one of:
  - halfword access with address_in[0] = 1;
  - word access with address_in[1:0] != 00;
  - size = 11.
  - misaligned_out is 0 when neither read nor write is asserted.
- Load (mem_read_in = 1, no fault), combinational, zero added latency:
  - byte: selected lane extended to 32 bits.
  - halfword: lanes {1,0} or {3,2}, extended.
  - word: the full word.
  - Extension follows mem_unsigned_in. It is ignored for word loads.
- read_data_out is 0 when mem_read_in = 0 or on a fault.
- Store (mem_write_in = 1, no fault), on the rising edge of clk:
  - byte: only the addressed lane is written, from write_data_in[7:0].
  - halfword: only the two addressed lanes, from write_data_in[15:0].
  - word: the full word.
  - Unaddressed lanes keep their value.
  - A faulting store writes nothing.
- Simultaneous read and write to the same word: read_data_out shows the pre-write contents during that cycle. The new value is visible from the next cycle.
- store_count_out increments by 1 per committed store. It wraps from 0xFFFF to 0x0000. Faulting stores do not count.
- Sticky fault register:
  - On a clock edge with misaligned_out = 1 and fault_sticky_out = 0: set fault_sticky_out and load fault_addr_out with address_in.
  - Later faults do not overwrite fault_addr_out.
  - fault_clear_in = 1 clears fault_sticky_out and fault_addr_out to 0 on the edge.
  - If clear and a new fault occur in the same cycle, clear wins; the new fault is lost.
- Reset, on a clock edge with rst = 1:
  - fault_sticky_out = 0, fault_addr_out = 0, store_count_out = 0.
  - Array cleared to 0 if INIT_ZERO = 1.
  - Any store presented in that cycle is discarded.
  - rst takes priority over fault_clear_in and over store or fault events.
  - Combinational outputs follow their inputs regardless of rst. After reset with INIT_ZERO = 1, loads return 0.
- Asserting both mem_read_in and mem_write_in is legal. The read returns the old data and the store commits.

Test Plan:
- Reset, then sw 0x8899AABB to 0x10, then lw 0x10 -> read_data_out = 0x8899AABB; store_count_out = 1.
- After the above:
  - lb 0x10 -> 0xFFFFFFBB; lbu 0x13 -> 0x00000088.
  - lh 0x12 -> 0xFFFF8899; lhu 0x10 -> 0x0000AABB.
- sb 0x11 with write_data_in = 0x00000055, then lw 0x10 -> 0x889955BB. sh 0x12 with 0x1234, then lw 0x10 -> 0x123455BB.
- Fault sequence:
  - sw to 0x22: misaligned_out = 1 and memory word 8 is unchanged.
  - Next cycle: fault_sticky_out = 1, fault_addr_out = 0x22, store_count_out unchanged.
  - lh 0x31: fault_addr_out stays 0x22.
  - fault_clear_in: sticky = 0, fault_addr_out = 0.
- Aliasing and counter wrap:
  - With ADDR_BITS = 8, sw 0xDEADBEEF to 0x400 -> lw 0x000 returns 0xDEADBEEF.
  - 65536 stores -> store_count_out wraps to 0.
- Mid-operation reset:
  - Assert rst together with sw 0xCAFEF00D to 0x40 while a fault is sticky -> store discarded, lw 0x40 = 0, fault_sticky_out = 0, store_count_out = 0.
  - A same-cycle lw/sw to 0x44 -> the read returns the old value and the new value appears next cycle.
